// File: rtl/sockit_ghrd_memtest_pkg.sv
// Shared types and helpers for the on-chip RAM tester: FSM states, default
// widths and the 64-bit test pattern generator.
package sockit_ghrd_memtest_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 64;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        FINISH
    } state_e;

    // Word i carries the seed mixed with its index in the upper half and the
    // complement in the lower half, so every data bit toggles across the range.
    function automatic logic [63:0] pattern(input logic [31:0] seed, input logic [31:0] idx);
        logic [31:0] mix;
        mix = seed ^ idx;
        return {mix, ~mix};
    endfunction

endpackage

// File: rtl/sockit_ghrd_memtest_checker.sv
// Read-response checker: tracks response order, compares against the pattern,
// keeps a saturating error count and (with MEMTEST_FIRST_FAIL_EN) the first failure.
module sockit_ghrd_memtest_checker
    import sockit_ghrd_memtest_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              rsp_valid,
    input  logic [63:0]       rsp_data,
    input  logic [31:0]       seed,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ERR_W-1:0]  err_count
`ifdef MEMTEST_FIRST_FAIL_EN
    ,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [63:0]       fail_data
`endif
);

    localparam int IDX_W = ADDR_W + 1;

    logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             mismatch;

    assign mismatch = rsp_valid && (rsp_data != pattern(seed, 32'(rsp_idx_q)));

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        rsp_idx_d = rsp_idx_q;
        err_d     = err_q;
        if (clear) begin
            rsp_idx_d = '0;
            err_d     = '0;
        end else if (rsp_valid) begin
            rsp_idx_d = rsp_idx_q + IDX_W'(1);
            if (mismatch && (err_q != '1)) begin
                err_d = err_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample the same edge.
        if (!reset_n) begin
            rsp_idx_q <= '0;
            err_q     <= '0;
        end else begin
            rsp_idx_q <= rsp_idx_d;
            err_q     <= err_d;
        end
    end

    assign err_count = err_q;

`ifdef MEMTEST_FIRST_FAIL_EN
    logic              fail_valid_q, fail_valid_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [63:0]       fail_data_q, fail_data_d;

    always_comb begin
        fail_valid_d = fail_valid_q;
        fail_addr_d  = fail_addr_q;
        fail_data_d  = fail_data_q;
        if (clear) begin
            fail_valid_d = 1'b0;
            fail_addr_d  = '0;
            fail_data_d  = '0;
        end else if (mismatch && !fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_addr_d  = base_addr + rsp_idx_q[ADDR_W-1:0];
            fail_data_d  = rsp_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fail_valid_q <= 1'b0;
            fail_addr_q  <= '0;
            fail_data_q  <= '0;
        end else begin
            fail_valid_q <= fail_valid_d;
            fail_addr_q  <= fail_addr_d;
            fail_data_q  <= fail_data_d;
        end
    end

    assign fail_valid = fail_valid_q;
    assign fail_addr  = fail_addr_q;
    assign fail_data  = fail_data_q;
`endif

endmodule

// File: rtl/sockit_ghrd_onchip_mem_tester.sv
// Avalon-MM memory tester: writes a seeded pattern over a word range, reads it
// back with up to MAX_PENDING reads in flight and reports pass/error count.
// Optional first-failure capture ports are enabled by MEMTEST_FIRST_FAIL_EN.
module sockit_ghrd_onchip_mem_tester
    import sockit_ghrd_memtest_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_PENDING = 4,
    parameter int ERR_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic              avm_read,
    output logic [7:0]        avm_byteenable,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid
`ifdef MEMTEST_FIRST_FAIL_EN
    ,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
`endif
);

    localparam int IDX_W  = ADDR_W + 1;
    localparam int PEND_W = 4;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  count_q, count_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       seed_q, seed_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic accepted;
    logic rd_acc;
    logic rsp_en;
    logic start_acc;

    assign accepted  = cs_q && !avm_waitrequest;
    assign rd_acc    = rd_q && accepted;
    // Responses only count while reads can actually be outstanding.
    assign rsp_en    = avm_readdatavalid && ((state_q == READ) || (state_q == DRAIN));
    assign start_acc = (state_q == IDLE) && start;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        count_d   = count_q;
        pending_d = pending_q;
        base_d    = base_q;
        seed_d    = seed_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        cs_d      = cs_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        if ((state_q == READ) || (state_q == DRAIN)) begin
            pending_d = pending_q + PEND_W'(rd_acc) - PEND_W'(rsp_en);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d    = base_addr;
                    count_d   = word_count;
                    seed_d    = seed;
                    busy_d    = 1'b1;
                    pass_d    = 1'b0;
                    idx_d     = '0;
                    pending_d = '0;
                    if (word_count == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = WRITE;
                        cs_d    = 1'b1;
                        wr_d    = 1'b1;
                        addr_d  = base_addr;
                        wdata_d = pattern(seed, 32'd0);
                    end
                end
            end
            WRITE: begin
                if (accepted) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_d == count_q) begin
                        // First read is presented straight away; nothing is pending yet.
                        state_d = READ;
                        idx_d   = '0;
                        wr_d    = 1'b0;
                        rd_d    = 1'b1;
                        addr_d  = base_q;
                        wdata_d = '0;
                    end else begin
                        addr_d  = base_q + idx_d[ADDR_W-1:0];
                        wdata_d = pattern(seed_q, 32'(idx_d));
                    end
                end
            end
            READ: begin
                if (rd_acc) begin
                    idx_d = idx_q + IDX_W'(1);
                end
                if (!(cs_q && avm_waitrequest)) begin
                    if (idx_d == count_q) begin
                        state_d = DRAIN;
                        cs_d    = 1'b0;
                        rd_d    = 1'b0;
                    end else begin
                        cs_d   = (pending_d < PEND_W'(MAX_PENDING));
                        rd_d   = (pending_d < PEND_W'(MAX_PENDING));
                        addr_d = base_q + idx_d[ADDR_W-1:0];
                    end
                end
            end
            DRAIN: begin
                // Waiting on the registered count means the last response is already scored.
                if (pending_q == '0) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_count == '0);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            count_q   <= '0;
            pending_q <= '0;
            base_q    <= '0;
            seed_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            cs_q      <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            base_q    <= base_d;
            seed_q    <= seed_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            cs_q      <= cs_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    sockit_ghrd_memtest_checker #(
        .ADDR_W (ADDR_W),
        .ERR_W  (ERR_W)
    ) u_checker (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (start_acc),
        .rsp_valid  (rsp_en),
        .rsp_data   (avm_readdata),
        .seed       (seed_q),
        .base_addr  (base_q),
        .err_count  (err_count)
`ifdef MEMTEST_FIRST_FAIL_EN
        ,
        .fail_valid (fail_valid),
        .fail_addr  (fail_addr),
        .fail_data  (fail_data)
`endif
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write      = wr_q;
    assign avm_read       = rd_q;
    assign avm_byteenable = cs_q ? 8'hFF : 8'h00;
    assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_sockit_ghrd_onchip_mem_tester.sv
// Bench for the memory tester: a behavioural Avalon slave with a word array,
// random stalls and in-order random read latency, plus directed test steps.
module tb_sockit_ghrd_onchip_mem_tester;

    localparam int ADDR_W      = 13;
    localparam int DATA_W      = 64;
    localparam int MAX_PENDING = 4;
    localparam int ERR_W       = 16;
    localparam int MEM_WORDS   = 1 << ADDR_W;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic [31:0]       seed;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_count;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic              avm_read;
    logic [7:0]        avm_byteenable;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
`ifdef MEMTEST_FIRST_FAIL_EN
    logic              fail_valid;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_data;
`endif

    sockit_ghrd_onchip_mem_tester #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MAX_PENDING (MAX_PENDING),
        .ERR_W       (ERR_W)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .base_addr         (base_addr),
        .word_count        (word_count),
        .seed              (seed),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .err_count         (err_count),
        .avm_address       (avm_address),
        .avm_chipselect    (avm_chipselect),
        .avm_write         (avm_write),
        .avm_read          (avm_read),
        .avm_byteenable    (avm_byteenable),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
`ifdef MEMTEST_FIRST_FAIL_EN
        ,
        .fail_valid        (fail_valid),
        .fail_addr         (fail_addr),
        .fail_data         (fail_data)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Test configuration shared with the slave model.
    logic [ADDR_W-1:0] cfg_base;
    int unsigned       cfg_count;
    logic [31:0]       cfg_seed;
    bit                wait_en, flip_en, spur_en;
    int unsigned       lat_max;
    int unsigned       wr_i, rd_i, cs_cycles, outstanding;

    function automatic logic [ADDR_W-1:0] exp_addr(input int unsigned i);
        return ADDR_W'((int'(cfg_base) + i) % MEM_WORDS);
    endfunction

    function automatic logic [63:0] exp_pat(input int unsigned i);
        logic [31:0] m;
        m = cfg_seed ^ i;
        return {m, ~m};
    endfunction

    typedef struct {
        int unsigned due;
        logic [63:0] data;
    } rsp_t;

    logic [63:0]       mem [MEM_WORDS];
    rsp_t              rsp_q[$];
    int unsigned       cyc, last_due;
    bit                stalled;
    logic [ADDR_W-1:0] h_addr;
    logic              h_wr, h_rd;
    logic [63:0]       h_wdata;

    // Slave: everything is decided on the falling edge, seen by the DUT on the next rising edge.
    initial begin : slave
        rsp_t        r;
        logic [63:0] d;
        bit          w;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        cyc = 0; last_due = 0; stalled = 0; outstanding = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                rsp_q.delete();
                avm_readdatavalid = 1'b0;
                avm_waitrequest   = 1'b0;
                outstanding = 0;
                stalled     = 0;
                last_due    = cyc;
            end else begin
                if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
                    r = rsp_q.pop_front();
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = r.data;
                    outstanding--;
                end else if (spur_en && avm_write) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = {$urandom, $urandom};
                end else begin
                    avm_readdatavalid = 1'b0;
                    avm_readdata      = {$urandom, $urandom};
                end
                if (stalled) begin
                    check("hold_cs", avm_chipselect, 1);
                    check("hold_addr", avm_address, h_addr);
                    check("hold_wr", avm_write, h_wr);
                    check("hold_rd", avm_read, h_rd);
                    check("hold_wdata", avm_writedata, h_wdata);
                end
                w = wait_en ? bit'($urandom_range(1, 0)) : 1'b0;
                avm_waitrequest = w;
                stalled = 0;
                if (avm_chipselect) begin
                    cs_cycles++;
                    check("one_cmd", avm_write & avm_read, 0);
                    check("byteenable", avm_byteenable, 8'hFF);
                    if (w) begin
                        stalled = 1;
                        h_addr = avm_address; h_wr = avm_write; h_rd = avm_read; h_wdata = avm_writedata;
                    end else if (avm_write) begin
                        check("wr_before_rd", rd_i, 0);
                        check("wr_addr", avm_address, exp_addr(wr_i));
                        check("wr_data", avm_writedata, exp_pat(wr_i));
                        mem[avm_address] = avm_writedata;
                        wr_i++;
                    end else begin
                        check("rd_after_wr", wr_i, cfg_count);
                        check("rd_addr", avm_address, exp_addr(rd_i));
                        d = mem[avm_address];
                        if (flip_en && (rd_i == 5 || rd_i == 9)) d[0] = ~d[0];
                        r.due = cyc + $urandom_range(lat_max, 1);
                        if (r.due <= last_due) r.due = last_due + 1;
                        last_due = r.due;
                        r.data   = d;
                        rsp_q.push_back(r);
                        rd_i++;
                        outstanding++;
                        check("pending_max", outstanding <= MAX_PENDING, 1);
                    end
                end
            end
        end
    end

    task automatic setup(input logic [ADDR_W-1:0] b, input int unsigned n, input logic [31:0] s,
                         input bit we, input int unsigned lmax, input bit flip, input bit spur);
        cfg_base = b; cfg_count = n; cfg_seed = s;
        wait_en = we; lat_max = lmax; flip_en = flip; spur_en = spur;
        wr_i = 0; rd_i = 0; cs_cycles = 0;
    endtask

    task automatic run_test(input string tag, input logic [ADDR_W-1:0] b, input int unsigned n,
                            input logic [31:0] s, input bit we, input int unsigned lmax,
                            input bit flip, input bit spur, input bit restart,
                            input int unsigned budget, output int unsigned waited);
        int unsigned exp_err;
        exp_err = flip ? (int'(n > 5) + int'(n > 9)) : 0;
        @(negedge clk);
        setup(b, n, s, we, lmax, flip, spur);
        start = 1'b1; base_addr = b; word_count = (ADDR_W+1)'(n); seed = s;
        @(negedge clk);
        start = 1'b0;
        // Scramble the inputs: the DUT must work from its sampled copies.
        base_addr = ADDR_W'($urandom); word_count = (ADDR_W+1)'($urandom); seed = $urandom;
        check({tag, "_busy"}, busy, 1);
        waited = 0;
        while (done !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
            start = restart && (waited == 10);
        end
        start = 1'b0;
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_err_count"}, err_count, exp_err);
        check({tag, "_pass"}, pass, exp_err == 0);
        check({tag, "_busy_clr"}, busy, 0);
        check({tag, "_writes"}, wr_i, n);
        check({tag, "_reads"}, rd_i, n);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_pass_hold"}, pass, exp_err == 0);
    endtask

    initial begin : main
        int unsigned waited;
        reset_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; seed = '0;
        setup('0, 0, '0, 0, 1, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_cs", avm_chipselect, 0);
        check("rst_wr", avm_write, 0);
        check("rst_rd", avm_read, 0);
        check("rst_addr", avm_address, 0);
        check("rst_be", avm_byteenable, 0);
        check("rst_wdata", avm_writedata, 0);
`ifdef MEMTEST_FIRST_FAIL_EN
        check("rst_fail_valid", fail_valid, 0);
        check("rst_fail_addr", fail_addr, 0);
        check("rst_fail_data", fail_data, 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        // Ideal slave, with stray readdatavalid pulses during the write phase.
        run_test("t1", 13'h0000, 16, 32'hA5A5_0000, 0, 1, 0, 1, 0, 500, waited);
        check("t1_word3", mem[3], 64'hA5A5_0003_5A5A_FFFC);
        check("t1_word15", mem[15], 64'hA5A5_000F_5A5A_FFF0);

        run_test("t2_wrap", 13'h1FFE, 4, 32'h1234_5678, 0, 1, 0, 0, 0, 500, waited);
        check("t2_mem1FFF", mem[13'h1FFF], exp_pat(1));
        check("t2_mem0000", mem[13'h0000], exp_pat(2));
        check("t2_mem0001", mem[13'h0001], exp_pat(3));

        run_test("t3_rand", ADDR_W'($urandom), 100, $urandom, 1, 6, 0, 0, 0, 5000, waited);

        run_test("t4_flip", 13'h0100, 16, 32'hDEAD_BEEF, 0, 1, 1, 0, 0, 500, waited);
`ifdef MEMTEST_FIRST_FAIL_EN
        check("t4_fail_valid", fail_valid, 1);
        check("t4_fail_addr", fail_addr, exp_addr(5));
        check("t4_fail_data", fail_data, exp_pat(5) ^ 64'd1);
`endif

        run_test("t5_zero", 13'h0040, 0, 32'h0, 1, 1, 0, 0, 0, 2, waited);
        check("t5_latency", waited <= 2, 1);
        check("t5_no_bus", cs_cycles, 0);
`ifdef MEMTEST_FIRST_FAIL_EN
        check("t5_fail_clear", fail_valid, 0);
`endif

        // Start pulse mid-run with scrambled inputs must be ignored.
        run_test("t6_busy_start", 13'h0200, 16, 32'h0F0F_0F0F, 1, 3, 0, 0, 1, 1000, waited);

        // Reset in the middle of the read phase.
        @(negedge clk);
        setup(13'h0300, 64, 32'hCAFE_0000, 1, 6, 0, 0);
        start = 1'b1; base_addr = 13'h0300; word_count = 14'd64; seed = 32'hCAFE_0000;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (avm_read !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        check("t7_in_read", busy, 1);
        reset_n = 1'b0;
        #1;
        check("t7_cs", avm_chipselect, 0);
        check("t7_rd", avm_read, 0);
        check("t7_wr", avm_write, 0);
        check("t7_addr", avm_address, 0);
        check("t7_be", avm_byteenable, 0);
        check("t7_busy", busy, 0);
        check("t7_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t7_no_done", done, 0);
        end
        reset_n = 1'b1;
        run_test("t8_after_rst", 13'h0400, 24, 32'h5555_AAAA, 1, 4, 0, 0, 0, 2000, waited);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/sockit_ghrd_onchip_mem_tester.md
Name: sockit_ghrd_onchip_mem_tester

Overview:
- Avalon-MM master that initiates the accesses the on-chip RAM slave responds to.
- Writes a deterministic 64-bit pattern over a programmable word range, then reads it back, compares and reports pass/fail with an error count.
- Sits in the FPGA fabric beside the on-chip RAM; used for bring-up and built-in self test, controlled by a simple start/done register interface from HPS-side CSR logic.

Parameters:
ADDR_W, 13, word-address width (8192 x 64-bit words)
DATA_W, 64, data width; fixed at 64, pattern definition depends on it
MAX_PENDING, 4, maximum outstanding read commands (1..15)
ERR_W, 16, error counter width, saturating

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a test when idle
base_addr  in  ADDR_W  first word address, sampled on start
word_count  in  ADDR_W+1  words to test (0..8192), sampled on start
seed  in  32  pattern seed, sampled on start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at test end
pass  out  1  valid from done until next start; 1 when err_count==0
err_count  out  ERR_W  mismatching words, saturates at all-ones
avm_address  out  ADDR_W  word address
avm_chipselect  out  1  command valid
avm_write  out  1  write command
avm_read  out  1  read command
avm_byteenable  out  8  always 8'hFF when a command is valid
avm_writedata  out  64  write data
avm_waitrequest  in  1  stall; command held while high
avm_readdata  in  64  read data
avm_readdatavalid  in  1  read response strobe, in command order

Behaviour:
- Reset: all outputs 0; state IDLE; counters cleared; pass=0.
- Pattern P(i), i = word index 0..word_count-1, zero-extended to 32 bits: P(i) = {seed ^ i, ~(seed ^ i)}.
- Address for index i: (base_addr + i) mod 2^ADDR_W (wraps silently).
- FSM: IDLE -> WRITE -> READ -> DRAIN -> FINISH -> IDLE.
  - IDLE: start latches inputs, clears err_count, sets busy. word_count==0 goes straight to FINISH with pass=1.
  - WRITE: chipselect=write=1. Index advances on each cycle with waitrequest low. After the last write is accepted -> READ. Throughput is one write per cycle with no stall.
  - READ: chipselect=read=1 while pending < MAX_PENDING and issue index < word_count. pending increments on accepted read, decrements on readdatavalid; both in the same cycle leaves it unchanged. When all reads are issued -> DRAIN.
  - DRAIN: wait until pending==0 -> FINISH.
  - FINISH: done=1 for one cycle, busy=0, pass=(err_count==0) -> IDLE.
- Compare: each readdatavalid checks readdata against P(rsp_idx); rsp_idx increments per response. A mismatch increments err_count, saturating at 2^ERR_W-1.
- Command signals stay stable while waitrequest=1; no command changes mid-stall.
- Only one command type is asserted per cycle; read and write are never both high.
- start while busy is ignored. readdatavalid outside READ/DRAIN is ignored.
- reset_n low mid-test aborts immediately: bus deasserted, no done pulse.

Optional Feature:
- Macro MEMTEST_FIRST_FAIL_EN.
- Defined:
  - adds outputs fail_addr (ADDR_W), fail_data (64) and fail_valid (1), all reset 0.
  - On the first mismatch after start, captures the word address and readdata and sets fail_valid.
  - Later mismatches do not overwrite. Captured values clear on the next accepted start.
- Undefined: ports and registers absent; behaviour otherwise identical.

Decomposition:
- Package sockit_ghrd_memtest_pkg: state enum (IDLE, WRITE, READ, DRAIN, FINISH), ADDR_W/DATA_W defaults, pattern function P(seed, idx).
- Sub-module sockit_ghrd_memtest_checker: response index counter, compare, saturating error counter, optional first-fail capture.

Test Plan:
- Ideal slave, no waitrequest, latency 1; base=0, count=16, seed=32'hA5A5_0000 -> 16 writes then 16 reads; done, pass=1, err_count=0; word 3 written as 64'hA5A5_0003_5A5A_FFFC.
- Wrap: base=13'h1FFE, count=4 -> addresses 1FFE, 1FFF, 0000, 0001 for both phases; pass=1.
- Random waitrequest (50%) and readdatavalid latency 1..6, MAX_PENDING=4, count=100 -> pending never exceeds 4; command stable during stalls; pass=1.
- Slave flips bit 0 of words 5 and 9, count=16 -> err_count=2, pass=0. With MEMTEST_FIRST_FAIL_EN: fail_addr=base+5, fail_data=P(5)^1.
- count=0 -> done within 2 cycles of start, pass=1, no bus activity. start during busy -> ignored.
- reset_n asserted during READ -> all avm outputs 0 immediately, busy=0, no done. A new start after release completes normally.
